// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code decoder: pops bytes from the receiver FIFO, folds E0/F0/E1
// prefixes into key events, tracks modifiers and typematic repeats, and maps keys to ASCII.
module ps2_scancode_decoder #(
  parameter int CNT_W   = 8,
  parameter int E1_SKIP = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_ready,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             shift,
  output logic             ctrl,
  output logic             caps,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  localparam int SKIP_W = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

  // Upstream handshake: in_ready means in_data is the FIFO head; the FIFO pops on the
  // edge where nextdata_n is sampled low. nextdata_n is low for exactly one cycle (ACK)
  // per byte, and in_ready is only looked at in IDLE, so a byte can never be popped twice.
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DECODE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               key_valid_q, key_valid_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic               key_break_q, key_break_d;
  logic               key_repeat_q, key_repeat_d;
  logic [7:0]         key_ascii_q, key_ascii_d;
  logic               lshift_q, lshift_d, rshift_q, rshift_d;
  logic               lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic               caps_q, caps_d;
  logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;
  logic               err_q, err_d;
  logic               ext_q, ext_d, brk_q, brk_d;
  logic [8:0]         held_q, held_d;
  logic               held_v_q, held_v_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic               held_match;

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
    logic [7:0] c;
    case (code)
      8'h1C: c = 8'h61; 8'h32: c = 8'h62; 8'h21: c = 8'h63; 8'h23: c = 8'h64;
      8'h24: c = 8'h65; 8'h2B: c = 8'h66; 8'h34: c = 8'h67; 8'h33: c = 8'h68;
      8'h43: c = 8'h69; 8'h3B: c = 8'h6A; 8'h42: c = 8'h6B; 8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D; 8'h31: c = 8'h6E; 8'h44: c = 8'h6F; 8'h4D: c = 8'h70;
      8'h15: c = 8'h71; 8'h2D: c = 8'h72; 8'h1B: c = 8'h73; 8'h2C: c = 8'h74;
      8'h3C: c = 8'h75; 8'h2A: c = 8'h76; 8'h1D: c = 8'h77; 8'h22: c = 8'h78;
      8'h35: c = 8'h79; 8'h1A: c = 8'h7A;
      8'h45: c = 8'h30; 8'h16: c = 8'h31; 8'h1E: c = 8'h32; 8'h26: c = 8'h33;
      8'h25: c = 8'h34; 8'h2E: c = 8'h35; 8'h36: c = 8'h36; 8'h3D: c = 8'h37;
      8'h3E: c = 8'h38; 8'h46: c = 8'h39;
      8'h29: c = 8'h20; 8'h5A: c = 8'h0D; 8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    // Only the lowercase letter range is affected by case selection.
    if (upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      key_ascii_q  <= 8'h00;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      lctrl_q      <= 1'b0;
      rctrl_q      <= 1'b0;
      caps_q       <= 1'b0;
      press_cnt_q  <= '0;
      err_q        <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= 9'h000;
      held_v_q     <= 1'b0;
      skip_q       <= '0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_repeat_q <= key_repeat_d;
      key_ascii_q  <= key_ascii_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      lctrl_q      <= lctrl_d;
      rctrl_q      <= rctrl_d;
      caps_q       <= caps_d;
      press_cnt_q  <= press_cnt_d;
      err_q        <= err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      held_q       <= held_d;
      held_v_q     <= held_v_d;
      skip_q       <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_ready) state_d = S_ACK;
      S_ACK:    state_d = S_DECODE;
      S_DECODE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign held_match = held_v_q && (held_q == {ext_q, byte_q});

  always_comb begin
    byte_d       = byte_q;
    nextdata_n_d = nextdata_n_q;
    key_valid_d  = 1'b0;
    err_d        = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    key_repeat_d = key_repeat_q;
    key_ascii_d  = key_ascii_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    lctrl_d      = lctrl_q;
    rctrl_d      = rctrl_q;
    caps_d       = caps_q;
    press_cnt_d  = press_cnt_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    held_d       = held_q;
    held_v_d     = held_v_q;
    skip_d       = skip_q;
    case (state_q)
      S_IDLE: begin
        if (in_ready) begin
          byte_d       = in_data;
          nextdata_n_d = 1'b0;
        end
      end
      S_ACK: nextdata_n_d = 1'b1;
      S_DECODE: begin
        if (skip_q != '0) begin
          skip_d = skip_q - SKIP_W'(1);
        end else if (byte_q == 8'hE1) begin
          skip_d = SKIP_W'(E1_SKIP);
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          key_valid_d = 1'b1;
          key_code_d  = byte_q;
          key_ext_d   = ext_q;
          key_break_d = brk_q;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
          if (brk_q) begin
            key_repeat_d = 1'b0;
            key_ascii_d  = 8'h00;
            if (held_match) held_v_d = 1'b0;
            if (!ext_q && byte_q == 8'h12) lshift_d = 1'b0;
            if (!ext_q && byte_q == 8'h59) rshift_d = 1'b0;
            if (!ext_q && byte_q == 8'h14) lctrl_d  = 1'b0;
            if (ext_q  && byte_q == 8'h14) rctrl_d  = 1'b0;
          end else begin
            key_repeat_d = held_match;
            key_ascii_d  = ext_q ? 8'h00
                                 : ascii_of(byte_q, (lshift_q | rshift_q) ^ caps_q);
            if (!held_match) begin
              held_d      = {ext_q, byte_q};
              held_v_d    = 1'b1;
              press_cnt_d = press_cnt_q + CNT_W'(1);
              if (!ext_q && byte_q == 8'h58) caps_d = ~caps_q;
            end
            if (!ext_q && byte_q == 8'h12) lshift_d = 1'b1;
            if (!ext_q && byte_q == 8'h59) rshift_d = 1'b1;
            if (!ext_q && byte_q == 8'h14) lctrl_d  = 1'b1;
            if (ext_q  && byte_q == 8'h14) rctrl_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign nextdata_n = nextdata_n_q;
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_break  = key_break_q;
  assign key_repeat = key_repeat_q;
  assign key_ascii  = key_ascii_q;
  assign shift      = lshift_q | rshift_q;
  assign ctrl       = lctrl_q | rctrl_q;
  assign caps       = caps_q;
  assign press_cnt  = press_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a byte-at-a-time FIFO driver, a negedge event
// monitor, and one task per scenario with hand-computed expectations.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_ready;
  logic       nextdata_n, key_valid, key_ext, key_break, key_repeat;
  logic [7:0] key_code, key_ascii;
  logic       shift, ctrl, caps, err;
  logic [7:0] press_cnt;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
  } ev_t;

  ev_t ev_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  err_cnt, low_cnt, last_low, min_gap, max_gap;

  ps2_scancode_decoder #(.CNT_W(8), .E1_SKIP(7)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_ready(in_ready),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
    .key_ascii(key_ascii), .shift(shift), .ctrl(ctrl), .caps(caps),
    .press_cnt(press_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: sample everything away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (key_valid === 1'b1)
      ev_q.push_back('{code: key_code, ext: key_ext, brk: key_break, rep: key_repeat, ascii: key_ascii});
    if (err === 1'b1) err_cnt = err_cnt + 1;
    if (nextdata_n === 1'b0) begin
      low_cnt = low_cnt + 1;
      if (last_low >= 0) begin
        if (cyc - last_low < min_gap) min_gap = cyc - last_low;
        if (cyc - last_low > max_gap) max_gap = cyc - last_low;
      end
      last_low = cyc;
    end
  end

  task automatic clear_mon();
    ev_q.delete();
    err_cnt  = 0;
    low_cnt  = 0;
    last_low = -1;
    min_gap  = 1000;
    max_gap  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_ready = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  // Present one byte; returns at the negedge after the FIFO pop edge, leaving in_ready high.
  task automatic send(input logic [7:0] b);
    bit got;
    got      = 1'b0;
    in_data  = b;
    in_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nextdata_n === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      errors = errors + 1;
      $display("FAIL pop_timeout byte=%h: no nextdata_n low within 20 cycles", b);
    end
    @(negedge clk);
  endtask

  task automatic idle_out();
    in_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_ready = 1'b1;
    in_data  = 8'h1C;
    repeat (2) @(negedge clk);
    checks = checks + 5;
    if (nextdata_n !== 1'b1) begin errors++; $display("FAIL reset_nextdata_n got=%b exp=1", nextdata_n); end
    if ({key_valid, err, key_ext, key_break, key_repeat} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {key_valid, err, key_ext, key_break, key_repeat});
    end
    if ({key_code, key_ascii} !== 16'h0) begin errors++; $display("FAIL reset_code_ascii got=%h exp=0000", {key_code, key_ascii}); end
    if ({shift, ctrl, caps} !== 3'b0) begin errors++; $display("FAIL reset_mods got=%b exp=000", {shift, ctrl, caps}); end
    if (press_cnt !== 8'd0) begin errors++; $display("FAIL reset_press_cnt got=%0d exp=0", press_cnt); end
    in_ready = 1'b0;
    rst      = 1'b0;
    clear_mon();
  endtask

  task automatic test_make_break();
    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C);
    idle_out();
    checks = checks + 6;
    if (ev_q.size() != 2) begin errors++; $display("FAIL mb_event_count got=%0d exp=2", ev_q.size()); end
    else begin
      if (ev_q[0] !== '{code: 8'h1C, ext: 1'b0, brk: 1'b0, rep: 1'b0, ascii: 8'h61}) begin
        errors++; $display("FAIL mb_make got=%h exp=%h", ev_q[0], ev_t'({8'h1C, 3'b000, 8'h61}));
      end
      if (ev_q[1] !== '{code: 8'h1C, ext: 1'b0, brk: 1'b1, rep: 1'b0, ascii: 8'h00}) begin
        errors++; $display("FAIL mb_break got=%h exp=%h", ev_q[1], ev_t'({8'h1C, 3'b010, 8'h00}));
      end
    end
    if (press_cnt !== 8'd1) begin errors++; $display("FAIL mb_press_cnt got=%0d exp=1", press_cnt); end
    if (low_cnt != 3) begin errors++; $display("FAIL mb_pops got=%0d exp=3", low_cnt); end
    if (key_code !== 8'h1C || key_break !== 1'b1) begin
      errors++; $display("FAIL mb_fields_hold got=%h/%b exp=1c/1", key_code, key_break);
    end
    clear_mon();
    send(8'h1C);
    idle_out();
    checks = checks + 2;
    if (ev_q.size() != 1 || ev_q[0].rep !== 1'b0) begin errors++; $display("FAIL mb_remake_norepeat events=%0d", ev_q.size()); end
    if (press_cnt !== 8'd2) begin errors++; $display("FAIL mb_remake_press_cnt got=%0d exp=2", press_cnt); end
  endtask

  task automatic test_shift_caps();
    do_reset();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h58);
    idle_out();
    checks = checks + 5;
    if (ev_q.size() != 4) begin errors++; $display("FAIL sc_event_count got=%0d exp=4", ev_q.size()); end
    else if (ev_q[1].ascii !== 8'h41) begin errors++; $display("FAIL sc_shift_ascii got=%h exp=41", ev_q[1].ascii); end
    if (shift !== 1'b0) begin errors++; $display("FAIL sc_shift got=%b exp=0", shift); end
    if (caps !== 1'b1) begin errors++; $display("FAIL sc_caps got=%b exp=1", caps); end
    if (press_cnt !== 8'd3) begin errors++; $display("FAIL sc_press_cnt got=%0d exp=3", press_cnt); end
    if (key_ascii !== 8'h00) begin errors++; $display("FAIL sc_caps_ascii got=%h exp=00", key_ascii); end
    send(8'h1C);
    idle_out();
    checks = checks + 2;
    if (key_ascii !== 8'h41) begin errors++; $display("FAIL sc_caps_upper got=%h exp=41", key_ascii); end
    if (press_cnt !== 8'd4) begin errors++; $display("FAIL sc_press_cnt2 got=%0d exp=4", press_cnt); end
    send(8'h58); send(8'h58);
    idle_out();
    checks = checks + 2;
    if (caps !== 1'b0 || key_repeat !== 1'b1) begin
      errors++; $display("FAIL sc_caps_repeat got=caps%b rep%b exp=caps0 rep1", caps, key_repeat);
    end
    if (press_cnt !== 8'd5) begin errors++; $display("FAIL sc_press_cnt3 got=%0d exp=5", press_cnt); end
  endtask

  task automatic test_repeat();
    do_reset();
    repeat (3) send(8'h1C);
    idle_out();
    checks = checks + 2;
    if (ev_q.size() != 3) begin errors++; $display("FAIL rep_event_count got=%0d exp=3", ev_q.size()); end
    else if ({ev_q[0].rep, ev_q[1].rep, ev_q[2].rep} !== 3'b011) begin
      errors++; $display("FAIL rep_flags got=%b exp=011", {ev_q[0].rep, ev_q[1].rep, ev_q[2].rep});
    end
    if (press_cnt !== 8'd1) begin errors++; $display("FAIL rep_press_cnt got=%0d exp=1", press_cnt); end
  endtask

  task automatic test_ext_pause();
    logic [7:0] pause_seq [9];
    do_reset();
    send(8'hE0); send(8'hF0); send(8'h75);
    idle_out();
    checks = checks + 1;
    if (ev_q.size() != 1 || ev_q[0] !== '{code: 8'h75, ext: 1'b1, brk: 1'b1, rep: 1'b0, ascii: 8'h00}) begin
      errors++; $display("FAIL ext_break events=%0d got=%h exp=%h", ev_q.size(), key_code, 8'h75);
    end
    clear_mon();
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    foreach (pause_seq[i]) send(pause_seq[i]);
    idle_out();
    checks = checks + 1;
    if (ev_q.size() != 1 || ev_q[0] !== '{code: 8'h29, ext: 1'b0, brk: 1'b0, rep: 1'b0, ascii: 8'h20}) begin
      errors++; $display("FAIL pause_skip events=%0d last_code=%h exp=one event 29/20", ev_q.size(), key_code);
    end
  endtask

  task automatic test_ctrl();
    do_reset();
    send(8'h14);
    idle_out();
    checks = checks + 1;
    if (ctrl !== 1'b1) begin errors++; $display("FAIL ctrl_left_make got=%b exp=1", ctrl); end
    send(8'hE0); send(8'h14); send(8'hF0); send(8'h14);
    idle_out();
    checks = checks + 2;
    if (ctrl !== 1'b1) begin errors++; $display("FAIL ctrl_right_held got=%b exp=1", ctrl); end
    if (key_ext !== 1'b0 || key_break !== 1'b1) begin errors++; $display("FAIL ctrl_left_break got=%b%b exp=01", key_ext, key_break); end
    send(8'hE0); send(8'hF0); send(8'h14);
    idle_out();
    checks = checks + 1;
    if (ctrl !== 1'b0) begin errors++; $display("FAIL ctrl_all_released got=%b exp=0", ctrl); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'hFF); send(8'h16); send(8'h1E);
    idle_out();
    checks = checks + 5;
    if (err_cnt != 1) begin errors++; $display("FAIL b2b_err_pulses got=%0d exp=1", err_cnt); end
    if (ev_q.size() != 2) begin errors++; $display("FAIL b2b_event_count got=%0d exp=2", ev_q.size()); end
    else begin
      if (ev_q[0].ascii !== 8'h31) begin errors++; $display("FAIL b2b_ascii1 got=%h exp=31", ev_q[0].ascii); end
      if (ev_q[1].ascii !== 8'h32) begin errors++; $display("FAIL b2b_ascii2 got=%h exp=32", ev_q[1].ascii); end
    end
    if (low_cnt != 3 || min_gap != 3 || max_gap != 3) begin
      errors++; $display("FAIL b2b_pop_rate pops=%0d gaps=%0d..%0d exp=3 pops gap 3", low_cnt, min_gap, max_gap);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    send(8'h58); send(8'hE0); send(8'hF0);
    in_ready = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    checks = checks + 3;
    if ({caps, press_cnt} !== 9'h0) begin errors++; $display("FAIL rst_mid_state got=caps%b cnt%0d exp=0/0", caps, press_cnt); end
    if ({key_code, key_ascii} !== 16'h0) begin errors++; $display("FAIL rst_mid_fields got=%h exp=0000", {key_code, key_ascii}); end
    if (nextdata_n !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_strobes got=%b%b exp=10", nextdata_n, key_valid); end
    rst = 1'b0;
    clear_mon();
    send(8'h1C);
    idle_out();
    checks = checks + 1;
    if (ev_q.size() != 1 || ev_q[0] !== '{code: 8'h1C, ext: 1'b0, brk: 1'b0, rep: 1'b0, ascii: 8'h61}) begin
      errors++; $display("FAIL rst_mid_plain_make events=%0d ext=%b brk=%b exp=1 event ext0 brk0", ev_q.size(), key_ext, key_break);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_ready = 1'b0;
    in_data  = 8'h00;
    clear_mon();
    test_reset();
    test_make_break();
    test_shift_caps();
    test_repeat();
    test_ext_pause();
    test_ctrl();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
